hdc_multiclass_engine: RTL and testbench

//  Parametrised N-class HDC associative memory with classifier; successor to the two-class train/predict controller.

---
 rtl/hdc_pkg.sv | 30 +++
 rtl/hdc_chunk_popcount.sv | 20 ++
 rtl/hdc_multiclass_engine.sv | 143 ++++++++++++++
 tb/tb_hdc_multiclass_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types and helpers for the multi-class HDC associative memory.
package hdc_pkg;

    typedef enum logic [1:0] {
        OP_TRAIN   = 2'b00,
        OP_PREDICT = 2'b01,
        OP_LOAD    = 2'b10,
        OP_CLEAR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_CMP  = 2'b10
    } state_e;

    // Step a w-bit signed counter toward +/- by one, clamping at its signed range.
    function automatic logic signed [31:0] sat_step(input logic signed [31:0] v,
                                                    input logic              up,
                                                    input int                w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (up)
            return (v >= hi) ? hi : v + 32'sd1;
        return (v <= lo) ? lo : v - 32'sd1;
    endfunction

endpackage

// File: rtl/hdc_chunk_popcount.sv
// Combinational Hamming distance of one PAR_BITS-wide chunk pair.
module hdc_chunk_popcount #(
    parameter int PAR_BITS = 10
) (
    input  logic [PAR_BITS-1:0]            a,
    input  logic [PAR_BITS-1:0]            b,
    output logic [$clog2(PAR_BITS+1)-1:0]  cnt
);
    localparam int PC_W = $clog2(PAR_BITS + 1);

    logic [PAR_BITS-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < PAR_BITS; i++)
            cnt = cnt + PC_W'(diff[i]);
    end
endmodule

// File: rtl/hdc_multiclass_engine.sv
// N-class HDC associative memory: chunked bundling/load/clear of per-class
// saturating counters and chunked Hamming-distance classification.
module hdc_multiclass_engine
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = 10000,
    parameter int PAR_BITS    = 10,
    parameter int NUM_CLASSES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic [1:0]                        op,
    input  logic [$clog2(NUM_CLASSES)-1:0]    label_in,
    input  logic [DIMENSIONS-1:0]             window_hv,
    output logic                              done,
    output logic                              err,
    output logic [NUM_CLASSES*DIMENSIONS-1:0] class_hv,
    output logic [$clog2(NUM_CLASSES)-1:0]    label_predict,
    output logic [$clog2(DIMENSIONS+1)-1:0]   dist_min
);
    localparam int N_CHUNKS = DIMENSIONS / PAR_BITS;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int LBL_W    = $clog2(NUM_CLASSES);
    localparam int DIST_W   = $clog2(DIMENSIONS + 1);
    localparam int PC_W     = $clog2(PAR_BITS + 1);

    state_e                               state_q, state_d;
    op_e                                  op_q;
    logic [LBL_W-1:0]                     label_q;
    logic [DIMENSIONS-1:0]                hv_q;
    logic [IDX_W-1:0]                     idx_q;
    logic [NUM_CLASSES-1:0][DIMENSIONS-1:0] chv;
    logic [NUM_CLASSES-1:0][DIST_W-1:0]   dist_q;
    logic [NUM_CLASSES-1:0][PC_W-1:0]     pc;
    logic [PAR_BITS-1:0]                  hv_chunk;
    logic                                 accept, label_ok, req_bad, last_chunk, upd_en;
    logic [LBL_W-1:0]                     best_idx;
    logic [DIST_W-1:0]                    best_d;

    assign accept     = (state_q == S_IDLE) && en;
    assign label_ok   = 32'(label_q) < 32'(NUM_CLASSES);
    assign req_bad    = ((op_q == OP_TRAIN) || (op_q == OP_LOAD)) && !label_ok;
    assign last_chunk = (idx_q == IDX_W'(N_CHUNKS - 1));
    assign upd_en     = (state_q == S_RUN) && !req_bad;
    assign done       = (state_q == S_IDLE);
    assign class_hv   = chv;
    assign hv_chunk   = hv_q[idx_q*PAR_BITS +: PAR_BITS];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (en) state_d = S_RUN;
            S_RUN: begin
                // A rejected request still spends one RUN cycle so done drops for a cycle.
                if (req_bad)         state_d = S_IDLE;
                else if (last_chunk) state_d = (op_q == OP_PREDICT) ? S_CMP : S_IDLE;
            end
            S_CMP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per class: chunk distance unit plus one saturating counter per HV bit.
    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
        logic sel;
        assign sel = (label_q == LBL_W'(c));

        hdc_chunk_popcount #(.PAR_BITS(PAR_BITS)) u_pc (
            .a   (hv_chunk),
            .b   (chv[c][idx_q*PAR_BITS +: PAR_BITS]),
            .cnt (pc[c])
        );

        for (genvar i = 0; i < DIMENSIONS; i++) begin : g_bit
            logic signed [CNT_W-1:0] cnt_q;
            logic                    hit;
            assign hit = upd_en && (idx_q == IDX_W'(i / PAR_BITS));

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    cnt_q <= '0;
                end else if (hit) begin
                    case (op_q)
                        OP_TRAIN: if (sel) cnt_q <= CNT_W'(sat_step(32'(cnt_q), hv_q[i], CNT_W));
                        OP_LOAD:  if (sel) cnt_q <= hv_q[i] ? CNT_W'(1) : '1;
                        OP_CLEAR: cnt_q <= '0;
                        default:  ;
                    endcase
                end
            end

            // Strictly positive counter; a zero tie reads as 0.
            assign chv[c][i] = !cnt_q[CNT_W-1] && (cnt_q != '0);
        end
    end

    always_comb begin
        best_idx = '0;
        best_d   = dist_q[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (dist_q[c] < best_d) begin
                best_d   = dist_q[c];
                best_idx = LBL_W'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_q          <= OP_TRAIN;
            label_q       <= '0;
            hv_q          <= '0;
            idx_q         <= '0;
            dist_q        <= '0;
            err           <= 1'b0;
            label_predict <= '0;
            dist_min      <= '0;
        end else if (accept) begin
            op_q    <= op_e'(op);
            label_q <= label_in;
            hv_q    <= window_hv;
            idx_q   <= '0;
            dist_q  <= '0;
            err     <= ((op == OP_TRAIN) || (op == OP_LOAD)) &&
                       (32'(label_in) >= 32'(NUM_CLASSES));
        end else if (state_q == S_RUN) begin
            idx_q <= idx_q + IDX_W'(1);
            if (op_q == OP_PREDICT)
                for (int c = 0; c < NUM_CLASSES; c++)
                    dist_q[c] <= dist_q[c] + DIST_W'(pc[c]);
        end else if (state_q == S_CMP) begin
            label_predict <= best_idx;
            dist_min      <= best_d;
        end
    end
endmodule

// File: tb/tb_hdc_multiclass_engine.sv
// Self-checking bench for hdc_multiclass_engine (16-bit HVs, 4-bit chunks, 3 classes).
module tb_hdc_multiclass_engine;
    localparam int D = 16;
    localparam int P = 4;
    localparam int C = 3;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [1:0]    label_in = 2'b00;
    logic [D-1:0]  window_hv = '0;
    logic          done, err;
    logic [C*D-1:0] class_hv;
    logic [1:0]    label_predict;
    logic [4:0]    dist_min;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: signed counters per class/bit, plus last-predict and err state.
    int         mcnt [C][D];
    logic       m_err;
    logic [1:0] m_lbl;
    int         m_dist;

    hdc_multiclass_engine #(.DIMENSIONS(D), .PAR_BITS(P), .NUM_CLASSES(C), .CNT_W(W)) dut (
        .clk(clk), .nrst(nrst), .en(en), .op(op), .label_in(label_in), .window_hv(window_hv),
        .done(done), .err(err), .class_hv(class_hv), .label_predict(label_predict),
        .dist_min(dist_min)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [C*D-1:0] m_chv();
        logic [C*D-1:0] r;
        r = '0;
        for (int c = 0; c < C; c++)
            for (int i = 0; i < D; i++)
                r[c*D+i] = (mcnt[c][i] > 0);
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [1:0] l);
        if ((o == 2'b00 || o == 2'b10) && l >= C) return 1;
        return (o == 2'b01) ? 5 : 4;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < C; c++)
            for (int i = 0; i < D; i++)
                mcnt[c][i] = 0;
        m_err = 1'b0; m_lbl = 2'd0; m_dist = 0;
    endtask

    task automatic m_apply(input logic [1:0] o, input logic [1:0] l, input logic [D-1:0] h);
        logic [C*D-1:0] cur;
        int best, d;
        m_err = (o == 2'b00 || o == 2'b10) && (l >= C);
        if (m_err) return;
        case (o)
            2'b00: for (int i = 0; i < D; i++)
                       mcnt[l][i] = h[i] ? ((mcnt[l][i] < 7) ? mcnt[l][i] + 1 : 7)
                                         : ((mcnt[l][i] > -8) ? mcnt[l][i] - 1 : -8);
            2'b10: for (int i = 0; i < D; i++) mcnt[l][i] = h[i] ? 1 : -1;
            2'b11: for (int c = 0; c < C; c++)
                       for (int i = 0; i < D; i++) mcnt[c][i] = 0;
            default: begin
                cur = m_chv();
                best = 1000;
                for (int c = 0; c < C; c++) begin
                    d = $countones(h ^ cur[c*D +: D]);
                    if (d < best) begin best = d; m_lbl = 2'(c); end
                end
                m_dist = best;
            end
        endcase
    endtask

    task automatic issue(input logic [1:0] o, input logic [1:0] l, input logic [D-1:0] h,
                         output int lat);
        @(negedge clk);
        op = o; label_in = l; window_hv = h; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL reset_done: got %b exp 1", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err); end
        n_tests++; if (class_hv !== '0) begin n_fail++; $display("FAIL reset_class_hv: got %h exp 0", class_hv); end
        n_tests++; if (label_predict !== 2'd0 || dist_min !== 5'd0) begin
            n_fail++; $display("FAIL reset_predict: got %0d/%0d exp 0/0", label_predict, dist_min); end
        @(negedge clk); nrst = 1'b1;
        m_reset();
    endtask

    task automatic test_load();
        logic [D-1:0] tbl [3];
        int lat;
        tbl[0] = 16'h00FF; tbl[1] = 16'hFF00; tbl[2] = 16'hF0F0;
        for (int c = 0; c < 3; c++) begin
            issue(2'b10, 2'(c), tbl[c], lat);
            m_apply(2'b10, 2'(c), tbl[c]);
            n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL load_lat[%0d]: got %0d exp 4", c, lat); end
        end
        n_tests++; if (class_hv !== 48'hF0F0_FF00_00FF) begin
            n_fail++; $display("FAIL load_class_hv: got %h exp f0f0ff0000ff", class_hv); end
    endtask

    task automatic test_predict();
        int lat;
        issue(2'b01, 2'd0, 16'h00FE, lat);
        m_apply(2'b01, 2'd0, 16'h00FE);
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL predict_lat: got %0d exp 5", lat); end
        n_tests++; if (label_predict !== 2'd0 || dist_min !== 5'd1) begin
            n_fail++; $display("FAIL predict_result: got %0d/%0d exp 0/1", label_predict, dist_min); end
        n_tests++; if (class_hv !== 48'hF0F0_FF00_00FF) begin
            n_fail++; $display("FAIL predict_class_hv: got %h exp f0f0ff0000ff", class_hv); end
    endtask

    task automatic test_tie();
        int lat;
        issue(2'b10, 2'd2, 16'h0000, lat);
        m_apply(2'b10, 2'd2, 16'h0000);
        issue(2'b01, 2'd0, 16'h0F0F, lat);
        m_apply(2'b01, 2'd0, 16'h0F0F);
        n_tests++; if (label_predict !== 2'd0 || dist_min !== 5'd8) begin
            n_fail++; $display("FAIL tie_result: got %0d/%0d exp 0/8", label_predict, dist_min); end
    endtask

    task automatic test_train_sat();
        int lat;
        issue(2'b11, 2'd3, 16'h1234, lat);
        m_apply(2'b11, 2'd3, 16'h1234);
        n_tests++; if (lat !== 4 || class_hv !== '0) begin
            n_fail++; $display("FAIL clear: got lat %0d hv %h exp 4/0", lat, class_hv); end
        for (int k = 0; k < 8; k++) begin
            issue(2'b00, 2'd1, 16'hFFFF, lat);
            m_apply(2'b00, 2'd1, 16'hFFFF);
        end
        // A wrapping counter would have gone negative on the 8th step.
        n_tests++; if (class_hv !== 48'h0000_FFFF_0000) begin
            n_fail++; $display("FAIL sat_high: got %h exp 0000ffff0000", class_hv); end
        issue(2'b00, 2'd1, 16'h0000, lat);
        m_apply(2'b00, 2'd1, 16'h0000);
        n_tests++; if (class_hv !== 48'h0000_FFFF_0000) begin
            n_fail++; $display("FAIL sat_step_down: got %h exp 0000ffff0000", class_hv); end
        for (int k = 0; k < 5; k++) begin
            issue(2'b00, 2'd1, 16'h0000, lat);
            m_apply(2'b00, 2'd1, 16'h0000);
        end
        n_tests++; if (class_hv !== 48'h0000_FFFF_0000) begin
            n_fail++; $display("FAIL sat_at_one: got %h exp 0000ffff0000", class_hv); end
        issue(2'b00, 2'd1, 16'h0000, lat);
        m_apply(2'b00, 2'd1, 16'h0000);
        n_tests++; if (class_hv !== '0) begin
            n_fail++; $display("FAIL sat_tie_zero: got %h exp 0", class_hv); end
    endtask

    task automatic test_err();
        logic [C*D-1:0] snap;
        int lat;
        issue(2'b10, 2'd0, 16'hA5A5, lat);
        m_apply(2'b10, 2'd0, 16'hA5A5);
        snap = m_chv();
        issue(2'b00, 2'd3, 16'hFFFF, lat);
        m_apply(2'b00, 2'd3, 16'hFFFF);
        n_tests++; if (lat !== 1 || err !== 1'b1) begin
            n_fail++; $display("FAIL err_train: got lat %0d err %b exp 1/1", lat, err); end
        n_tests++; if (class_hv !== snap) begin
            n_fail++; $display("FAIL err_class_hv: got %h exp %h", class_hv, snap); end
        issue(2'b10, 2'd3, 16'h0000, lat);
        m_apply(2'b10, 2'd3, 16'h0000);
        n_tests++; if (lat !== 1 || err !== 1'b1 || class_hv !== snap) begin
            n_fail++; $display("FAIL err_load: got lat %0d err %b hv %h", lat, err, class_hv); end
        issue(2'b01, 2'd3, 16'hA5A4, lat);
        m_apply(2'b01, 2'd3, 16'hA5A4);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b exp 0", err); end
    endtask

    task automatic test_busy_ignore();
        logic [D-1:0] h;
        int lat;
        h = 16'($urandom);
        @(negedge clk);
        op = 2'b00; label_in = 2'd0; window_hv = h; en = 1'b1;
        @(posedge clk); #1;
        op = 2'b10; label_in = 2'd2; window_hv = ~h;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        en = 1'b0;
        m_apply(2'b00, 2'd0, h);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL busy_lat: got %0d exp 4", lat); end
        n_tests++; if (class_hv !== m_chv()) begin
            n_fail++; $display("FAIL busy_class_hv: got %h exp %h", class_hv, m_chv()); end
    endtask

    task automatic test_random();
        logic [1:0] o, l;
        logic [D-1:0] h;
        int lat;
        for (int k = 0; k < 40; k++) begin
            o = 2'($urandom_range(0, 3));
            l = 2'($urandom_range(0, 3));
            h = 16'($urandom);
            issue(o, l, h, lat);
            m_apply(o, l, h);
            n_tests++; if (lat !== exp_lat(o, l)) begin
                n_fail++; $display("FAIL rnd_lat[%0d]: op %0d got %0d exp %0d", k, o, lat, exp_lat(o, l)); end
            n_tests++; if (err !== m_err) begin
                n_fail++; $display("FAIL rnd_err[%0d]: got %b exp %b", k, err, m_err); end
            n_tests++; if (class_hv !== m_chv()) begin
                n_fail++; $display("FAIL rnd_class_hv[%0d]: got %h exp %h", k, class_hv, m_chv()); end
            n_tests++; if (label_predict !== m_lbl || dist_min !== 5'(m_dist)) begin
                n_fail++; $display("FAIL rnd_predict[%0d]: got %0d/%0d exp %0d/%0d",
                                   k, label_predict, dist_min, m_lbl, m_dist); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(2'b10, 2'd2, 16'h3C3C, lat);
        m_apply(2'b10, 2'd2, 16'h3C3C);
        issue(2'b01, 2'd0, 16'h3C3C, lat);
        m_apply(2'b01, 2'd0, 16'h3C3C);
        n_tests++; if (label_predict !== m_lbl || dist_min !== 5'(m_dist)) begin
            n_fail++; $display("FAIL mid_setup: got %0d/%0d exp %0d/%0d", label_predict, dist_min, m_lbl, m_dist); end
        @(negedge clk);
        op = 2'b01; window_hv = 16'hFFFF; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        n_tests++; if (done !== 1'b1 || class_hv !== '0) begin
            n_fail++; $display("FAIL mid_reset_state: got done %b hv %h exp 1/0", done, class_hv); end
        n_tests++; if (label_predict !== 2'd0 || dist_min !== 5'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %0d/%0d err %b exp 0/0/0",
                               label_predict, dist_min, err); end
        @(negedge clk); nrst = 1'b1;
        m_reset();
    endtask

    initial begin
        test_reset();
        test_load();
        test_predict();
        test_tie();
        test_train_sat();
        test_err();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
